// File: rtl/lfsr5b_checker_if.sv
// Receive-side bus for the x^5+x^2+1 PRBS checker: serial input, control and status.
interface lfsr5b_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             bit_in;
  logic             bit_vld;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic             sync_loss;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output bit_in, bit_vld, clr_cnt,
    input  locked, err_pulse, sync_loss, err_cnt, bit_cnt
  );

  modport slave (
    input  bit_in, bit_vld, clr_cnt,
    output locked, err_pulse, sync_loss, err_cnt, bit_cnt
  );
endinterface

// File: rtl/lfsr5b_checker.sv
// Self-synchronising serial checker for the 5-bit PRBS (s(n) = s(n-3) ^ s(n-5), period 31).
// Locks after LOCK_CNT correct predictions, then free-runs a local reference and counts errors.
module lfsr5b_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned ERR_WIN  = 31,
  parameter int unsigned ERR_MAX  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  lfsr5b_checker_if.slave   bus
);

  localparam int unsigned FILL_W  = 3;
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = $clog2(ERR_WIN + 1);
  localparam int unsigned WERR_W  = $clog2(ERR_MAX + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  logic [4:0]         r_h;
  logic [FILL_W-1:0]  r_fill;
  logic [MATCH_W-1:0] r_match;
  logic [WIN_W-1:0]   r_win;
  logic [WERR_W-1:0]  r_werr;
  logic               r_locked;
  logic               r_err_pulse;
  logic               r_sync_loss;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   r_bit_cnt;

  logic               w_pred;
  logic               w_mis;
  logic [4:0]         w_h_shift;
  logic [WERR_W-1:0]  w_werr_nxt;
  logic               w_loss;
  logic               w_win_end;
  logic [CNT_W-1:0]   w_err_inc;
  logic [CNT_W-1:0]   w_bit_inc;

  // Prediction from history (h[0] newest) and per-bit window bookkeeping.
  assign w_pred     = r_h[2] ^ r_h[4];
  assign w_mis      = bus.bit_in ^ w_pred;
  assign w_h_shift  = {r_h[3:0], bus.bit_in};
  assign w_werr_nxt = r_werr + WERR_W'(w_mis);
  assign w_loss     = (w_werr_nxt == WERR_W'(ERR_MAX));
  assign w_win_end  = (r_win == WIN_W'(ERR_WIN - 1));
  assign w_err_inc  = (r_err_cnt == {CNT_W{1'b1}}) ? r_err_cnt : r_err_cnt + CNT_W'(1);
  assign w_bit_inc  = (r_bit_cnt == {CNT_W{1'b1}}) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_h         <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_sync_loss <= 1'b0;
      r_err_cnt   <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      r_sync_loss <= 1'b0;
      if (bus.clr_cnt) begin
        r_err_cnt <= '0;
        r_bit_cnt <= '0;
      end
      if (bus.bit_vld) begin
        case (r_state)
          ST_SEARCH: begin
            r_h <= w_h_shift;
            // Once five bits are in, any non-zero history is a usable seed.
            if (r_fill >= FILL_W'(4)) begin
              r_fill <= FILL_W'(5);
              if (w_h_shift != 5'd0) begin
                r_state <= ST_VERIFY;
                r_match <= '0;
              end
            end else begin
              r_fill <= r_fill + FILL_W'(1);
            end
          end
          ST_VERIFY: begin
            r_h <= w_h_shift;
            if (w_mis) begin
              r_state <= ST_SEARCH;
              r_fill  <= '0;
              r_match <= '0;
            end else if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_win    <= '0;
              r_werr   <= '0;
            end else begin
              r_match <= r_match + MATCH_W'(1);
            end
          end
          ST_LOCKED: begin
            // Reference free-runs so received errors never pollute it.
            r_h <= {r_h[3:0], w_pred};
            if (!bus.clr_cnt) r_bit_cnt <= w_bit_inc;
            if (w_mis) begin
              r_err_pulse <= 1'b1;
              if (!bus.clr_cnt) r_err_cnt <= w_err_inc;
            end
            if (w_loss) begin
              r_state     <= ST_SEARCH;
              r_fill      <= '0;
              r_match     <= '0;
              r_locked    <= 1'b0;
              r_sync_loss <= 1'b1;
              r_win       <= '0;
              r_werr      <= '0;
            end else if (w_win_end) begin
              r_win  <= '0;
              r_werr <= '0;
            end else begin
              r_win  <= r_win + WIN_W'(1);
              r_werr <= w_werr_nxt;
            end
          end
          default: begin
            r_state <= ST_SEARCH;
            r_fill  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.sync_loss = r_sync_loss;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_lfsr5b_checker.sv
// Directed bench for lfsr5b_checker using a hand-computed 31-bit reference sequence (seed 11111).
module tb_lfsr5b_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   ph      = 0;
  int   idle_bad = 0;
  // One full period, first bit in the MSB: 1,1,1,0,0,0,1,1,0,1,1,1,0,1,0,1,0,0,0,0,1,0,0,1,0,1,1,0,0,1,1
  logic [30:0] seq = 31'b1110001101110101000010010110011;

  lfsr5b_checker_if #(.CNT_W(16)) bus ();

  lfsr5b_checker #(
    .LOCK_CNT(8), .ERR_WIN(31), .ERR_MAX(4), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic ref_bit(input int idx);
    return seq[30 - (idx % 31)];
  endfunction

  task automatic drive(input logic b, input logic v, input logic clr);
    bus.bit_in  = b;
    bus.bit_vld = v;
    bus.clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ref(input logic inv);
    drive(ref_bit(ph) ^ inv, 1'b1, 1'b0);
    ph++;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (bus.err_pulse !== 1'b0 || bus.sync_loss !== 1'b0) idle_bad++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    ph  = 0;
  endtask

  task automatic lock_up();
    repeat (13) send_ref(1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.locked !== 1'b0) $display("FAIL rst_locked: got %b want 0", bus.locked); else n_pass++;
    n_total++; if (bus.err_pulse !== 1'b0) $display("FAIL rst_err_pulse: got %b want 0", bus.err_pulse); else n_pass++;
    n_total++; if (bus.sync_loss !== 1'b0) $display("FAIL rst_sync_loss: got %b want 0", bus.sync_loss); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd0) $display("FAIL rst_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd0) $display("FAIL rst_bit_cnt: got %0d want 0", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_lock();
    int bad;
    bad = 0;
    do_reset();
    repeat (12) begin
      send_ref(1'b0);
      if (bus.locked !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL early_lock: %0d early locked cycles want 0", bad); else n_pass++;
    send_ref(1'b0);
    n_total++; if (bus.locked !== 1'b1) $display("FAIL lock_at_13: got %b want 1", bus.locked); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd0) $display("FAIL lock_bit_cnt0: got %0d want 0", bus.bit_cnt); else n_pass++;
    bad = 0;
    repeat (20) begin
      send_ref(1'b0);
      if (bus.err_pulse !== 1'b0) bad++;
    end
    n_total++; if (bus.bit_cnt !== 16'd20) $display("FAIL clean_bit_cnt: got %0d want 20", bus.bit_cnt); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd0) $display("FAIL clean_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL clean_pulses: %0d err pulses want 0", bad); else n_pass++;
  endtask

  task automatic test_single_error();
    send_ref(1'b1);
    n_total++; if (bus.err_pulse !== 1'b1) $display("FAIL single_pulse: got %b want 1", bus.err_pulse); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd1) $display("FAIL single_err_cnt: got %0d want 1", bus.err_cnt); else n_pass++;
    n_total++; if (bus.locked !== 1'b1) $display("FAIL single_locked: got %b want 1", bus.locked); else n_pass++;
    send_ref(1'b0);
    n_total++; if (bus.err_pulse !== 1'b0) $display("FAIL single_pulse_end: got %b want 0", bus.err_pulse); else n_pass++;
    repeat (30) send_ref(1'b0);
    n_total++; if (bus.err_cnt !== 16'd1) $display("FAIL single_after: err_cnt %0d want 1", bus.err_cnt); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd52) $display("FAIL single_bit_cnt: got %0d want 52", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_sync_loss();
    int bad;
    bad = 0;
    do_reset();
    lock_up();
    for (int k = 0; k < 6; k++) begin
      send_ref(k % 2 == 0);
      if (bus.sync_loss !== 1'b0 || bus.locked !== 1'b1) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL loss_early: %0d bad cycles want 0", bad); else n_pass++;
    send_ref(1'b1);
    n_total++; if (bus.sync_loss !== 1'b1) $display("FAIL loss_pulse: got %b want 1", bus.sync_loss); else n_pass++;
    n_total++; if (bus.locked !== 1'b0) $display("FAIL loss_locked: got %b want 0", bus.locked); else n_pass++;
    n_total++; if (bus.err_pulse !== 1'b1) $display("FAIL loss_err_pulse: got %b want 1", bus.err_pulse); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd4) $display("FAIL loss_err_cnt: got %0d want 4", bus.err_cnt); else n_pass++;
    send_ref(1'b0);
    n_total++; if (bus.sync_loss !== 1'b0) $display("FAIL loss_pulse_end: got %b want 0", bus.sync_loss); else n_pass++;
    bad = 0;
    repeat (11) begin
      send_ref(1'b0);
      if (bus.locked !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL relock_early: %0d early cycles want 0", bad); else n_pass++;
    send_ref(1'b0);
    n_total++; if (bus.locked !== 1'b1) $display("FAIL relock_13: got %b want 1", bus.locked); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd4) $display("FAIL relock_err_cnt: got %0d want 4", bus.err_cnt); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd7) $display("FAIL relock_bit_cnt: got %0d want 7", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_window();
    do_reset();
    lock_up();
    repeat (3) send_ref(1'b1);
    repeat (28) send_ref(1'b0);
    n_total++; if (bus.locked !== 1'b1) $display("FAIL win_locked31: got %b want 1", bus.locked); else n_pass++;
    send_ref(1'b1);
    n_total++; if (bus.sync_loss !== 1'b0) $display("FAIL win_rollover: sync_loss %b want 0", bus.sync_loss); else n_pass++;
    n_total++; if (bus.locked !== 1'b1) $display("FAIL win_locked32: got %b want 1", bus.locked); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd4) $display("FAIL win_err_cnt: got %0d want 4", bus.err_cnt); else n_pass++;
  endtask

  task automatic test_all_zero();
    int bad;
    bad = 0;
    do_reset();
    repeat (100) begin
      drive(1'b0, 1'b1, 1'b0);
      if (bus.locked !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL zero_lock: %0d locked cycles want 0", bad); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd0) $display("FAIL zero_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd0) $display("FAIL zero_bit_cnt: got %0d want 0", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_gaps();
    int bad;
    bad = 0;
    idle_bad = 0;
    do_reset();
    repeat (8) begin
      send_ref(1'b0);
      idle_gap();
    end
    send_ref(1'b1);
    idle_gap();
    repeat (12) begin
      send_ref(1'b0);
      if (bus.locked !== 1'b0) bad++;
      idle_gap();
      if (bus.locked !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL gap_early: %0d locked cycles want 0", bad); else n_pass++;
    send_ref(1'b0);
    n_total++; if (bus.locked !== 1'b1) $display("FAIL gap_lock: got %b want 1", bus.locked); else n_pass++;
    bad = 0;
    repeat (10) begin
      idle_gap();
      if (bus.locked !== 1'b1) bad++;
      send_ref(1'b0);
    end
    n_total++; if (bad != 0) $display("FAIL gap_hold: %0d unlocked idles want 0", bad); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd10) $display("FAIL gap_bit_cnt: got %0d want 10", bus.bit_cnt); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd0) $display("FAIL gap_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
    n_total++; if (idle_bad != 0) $display("FAIL gap_idle_pulse: %0d pulses want 0", idle_bad); else n_pass++;
  endtask

  task automatic test_rst_locked();
    do_reset();
    lock_up();
    send_ref(1'b1);
    send_ref(1'b0);
    send_ref(1'b1);
    send_ref(1'b0);
    send_ref(1'b1);
    n_total++; if (bus.err_cnt !== 16'd3) $display("FAIL pre_rst_err_cnt: got %0d want 3", bus.err_cnt); else n_pass++;
    rst = 1'b1;
    drive(~ref_bit(ph), 1'b1, 1'b0);
    rst = 1'b0;
    ph  = 0;
    n_total++; if (bus.locked !== 1'b0) $display("FAIL midrst_locked: got %b want 0", bus.locked); else n_pass++;
    n_total++; if (bus.err_pulse !== 1'b0) $display("FAIL midrst_pulse: got %b want 0", bus.err_pulse); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd0) $display("FAIL midrst_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd0) $display("FAIL midrst_bit_cnt: got %0d want 0", bus.bit_cnt); else n_pass++;
    n_total++; if (bus.sync_loss !== 1'b0) $display("FAIL midrst_sync: got %b want 0", bus.sync_loss); else n_pass++;
  endtask

  task automatic test_clr_same_cycle();
    do_reset();
    lock_up();
    send_ref(1'b1);
    repeat (2) send_ref(1'b0);
    drive(~ref_bit(ph), 1'b1, 1'b1);
    ph++;
    n_total++; if (bus.err_pulse !== 1'b1) $display("FAIL clr_pulse: got %b want 1", bus.err_pulse); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd0) $display("FAIL clr_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
    n_total++; if (bus.bit_cnt !== 16'd0) $display("FAIL clr_bit_cnt: got %0d want 0", bus.bit_cnt); else n_pass++;
    send_ref(1'b0);
    n_total++; if (bus.bit_cnt !== 16'd1) $display("FAIL clr_resume: bit_cnt %0d want 1", bus.bit_cnt); else n_pass++;
    n_total++; if (bus.err_cnt !== 16'd0) $display("FAIL clr_hold: err_cnt %0d want 0", bus.err_cnt); else n_pass++;
  endtask

  initial begin
    bus.bit_in  = 1'b0;
    bus.bit_vld = 1'b0;
    bus.clr_cnt = 1'b0;
    test_reset();
    test_lock();
    test_single_error();
    test_sync_loss();
    test_window();
    test_all_zero();
    test_gaps();
    test_rst_locked();
    test_clr_same_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
